// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg
//   Shared types for the multi-port register file. Only the sequencer state
//   lives here; address/data widths depend on per-instance parameters and are
//   therefore declared inside each module.
package regfile_mp_pkg;

  typedef enum logic {
    SWEEP = 1'b0,
    READY = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if
//   Bus bundle for regfile_mp: clear/ready handshake, N read ports and two
//   write ports.
//   master : drives clear, raddr, we0/we1, waddr0/waddr1, wdata0/wdata1;
//            receives ready, rdata
//   slave  : the register file side (mirror of master)
//   raddr port p sits at [p*AW +: AW], rdata port p at
//   [p*DATA_WIDTH +: DATA_WIDTH].
interface regfile_mp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int NUM_READ   = 2
);
  localparam int AW = $clog2(NUM_REGS);

  logic                           clear;
  logic                           ready;
  logic [NUM_READ*AW-1:0]         raddr;
  logic [NUM_READ*DATA_WIDTH-1:0] rdata;
  logic                           we0;
  logic                           we1;
  logic [AW-1:0]                  waddr0;
  logic [AW-1:0]                  waddr1;
  logic [DATA_WIDTH-1:0]          wdata0;
  logic [DATA_WIDTH-1:0]          wdata1;

  modport master (
    output clear, raddr, we0, we1, waddr0, waddr1, wdata0, wdata1,
    input  ready, rdata
  );

  modport slave (
    input  clear, raddr, we0, we1, waddr0, waddr1, wdata0, wdata1,
    output ready, rdata
  );

endinterface

// File: rtl/regfile_mp.sv
// regfile_mp
//   Parametrised register file: NUM_READ registered read ports with
//   write-first bypass, two write ports (port 1 wins on collision), optional
//   hard-wired zero register, and a sweep sequencer that zeroes the array
//   after reset or on a clear request.
//   Ports:
//     clk    : system clock, rising edge
//     rst_n  : asynchronous active-low reset (forces SWEEP, index 0, rdata 0)
//     bus    : regfile_mp_if.slave (clear, ready, raddr, rdata, write ports)
//
// state | meaning
// SWEEP | zeroing reg[index] each clock; reads return 0, writes/clear ignored
// READY | array valid; reads and writes honoured, clear restarts the sweep
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int NUM_READ   = 2,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_mp_if.slave  bus
);

  localparam int AW = $clog2(NUM_REGS);

  state_e                state_q, state_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic                  wr_open;
  logic                  acc0, acc1;
  logic [DATA_WIDTH-1:0] mem [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SWEEP;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr_open = 1'b0;
    unique case (state_q)
      SWEEP: begin
        idx_d = idx_q + AW'(1);
        if (idx_q == AW'(NUM_REGS - 1)) begin
          state_d = READY;
          idx_d   = '0;
        end
      end
      READY: begin
        if (bus.clear) begin
          state_d = SWEEP;
          idx_d   = '0;
        end else begin
          wr_open = 1'b1;
        end
      end
      default: begin
        state_d = SWEEP;
        idx_d   = '0;
      end
    endcase
  end

  assign bus.ready = (state_q == READY);

  // Accepted writes; register 0 is read-only when hard-wired to zero.
  assign acc0 = wr_open && bus.we0 && !(ZERO_REG && (bus.waddr0 == '0));
  assign acc1 = wr_open && bus.we1 && !(ZERO_REG && (bus.waddr1 == '0));

  // No reset on the array: the sweep provides the zeroing. Port 1 is written
  // last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (state_q == SWEEP) begin
      mem[idx_q] <= '0;
    end else begin
      if (acc0) mem[bus.waddr0] <= bus.wdata0;
      if (acc1) mem[bus.waddr1] <= bus.wdata1;
    end
  end

  for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
    logic [AW-1:0]         ra;
    logic [DATA_WIDTH-1:0] rd_q;

    assign ra = bus.raddr[p*AW +: AW];

    // Zeroed while sweeping and on the clear edge, so no stale or
    // not-yet-swept word leaks out before ready.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_q <= '0;
      end else if (state_q != READY || bus.clear) begin
        rd_q <= '0;
      end else if (ZERO_REG && (ra == '0)) begin
        rd_q <= '0;
      end else if (acc1 && (bus.waddr1 == ra)) begin
        rd_q <= bus.wdata1;
      end else if (acc0 && (bus.waddr0 == ra)) begin
        rd_q <= bus.wdata0;
      end else begin
        rd_q <= mem[ra];
      end
    end

    assign bus.rdata[p*DATA_WIDTH +: DATA_WIDTH] = rd_q;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp
//   Directed bench for regfile_mp. dut_a: 32x32, 2 read ports, zero register.
//   dut_b: 32x32, 4 read ports, no zero register.
module tb_regfile_mp;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  regfile_mp_if #(.DATA_WIDTH(32), .NUM_REGS(32), .NUM_READ(2)) bus_a ();
  regfile_mp_if #(.DATA_WIDTH(32), .NUM_REGS(32), .NUM_READ(4)) bus_b ();

  regfile_mp #(
    .DATA_WIDTH(32), .NUM_REGS(32), .NUM_READ(2), .ZERO_REG(1'b1)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  regfile_mp #(
    .DATA_WIDTH(32), .NUM_REGS(32), .NUM_READ(4), .ZERO_REG(1'b0)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks ready against "rises exactly on edge 32" while stepping edges.
  task automatic test_reset();
    logic exp_rdy;
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #20;
    total_cnt++;
    if (bus_a.ready !== 1'b0) $display("FAIL reset_ready_a got=%b exp=0", bus_a.ready);
    else pass_cnt++;
    total_cnt++;
    if (bus_a.rdata !== 64'h0) $display("FAIL reset_rdata_a got=%h exp=0", bus_a.rdata);
    else pass_cnt++;
    total_cnt++;
    if (bus_b.rdata !== 128'h0) $display("FAIL reset_rdata_b got=%h exp=0", bus_b.rdata);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      tick();
      exp_rdy = (i == 32);
      total_cnt++;
      if (bus_a.ready !== exp_rdy)
        $display("FAIL reset_sweep_ready edge=%0d got=%b exp=%b", i, bus_a.ready, exp_rdy);
      else pass_cnt++;
    end
    total_cnt++;
    if (bus_b.ready !== 1'b1) $display("FAIL reset_ready_b got=%b exp=1", bus_b.ready);
    else pass_cnt++;
    for (int r = 0; r < 32; r++) begin
      bus_a.raddr[4:0] = r[4:0];
      tick();
      total_cnt++;
      if (bus_a.rdata[31:0] !== 32'h0)
        $display("FAIL reset_read reg=%0d got=%h exp=0", r, bus_a.rdata[31:0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_collision();
    bus_a.we0 = 1'b1; bus_a.waddr0 = 5'd5; bus_a.wdata0 = 32'hAAAA_0000;
    bus_a.we1 = 1'b1; bus_a.waddr1 = 5'd5; bus_a.wdata1 = 32'h0000_5555;
    bus_a.raddr = {5'd6, 5'd5};
    tick();
    total_cnt++;
    if (bus_a.rdata[31:0] !== 32'h0000_5555)
      $display("FAIL collision_bypass got=%h exp=00005555", bus_a.rdata[31:0]);
    else pass_cnt++;
    total_cnt++;
    if (bus_a.rdata[63:32] !== 32'h0)
      $display("FAIL collision_other_port got=%h exp=0", bus_a.rdata[63:32]);
    else pass_cnt++;
    bus_a.we0 = 1'b0; bus_a.we1 = 1'b0;
    tick();
    total_cnt++;
    if (bus_a.rdata[31:0] !== 32'h0000_5555)
      $display("FAIL collision_persist got=%h exp=00005555", bus_a.rdata[31:0]);
    else pass_cnt++;
  endtask

  task automatic test_zero_reg();
    bus_a.we0 = 1'b1; bus_a.waddr0 = 5'd0; bus_a.wdata0 = 32'hDEADBEEF;
    bus_b.we0 = 1'b1; bus_b.waddr0 = 5'd0; bus_b.wdata0 = 32'hDEADBEEF;
    bus_a.raddr = {5'd0, 5'd5};
    bus_b.raddr = {5'd0, 5'd0, 5'd0, 5'd0};
    tick();
    total_cnt++;
    if (bus_a.rdata[63:32] !== 32'h0)
      $display("FAIL zero_reg_same got=%h exp=0", bus_a.rdata[63:32]);
    else pass_cnt++;
    total_cnt++;
    if (bus_b.rdata[63:32] !== 32'hDEADBEEF)
      $display("FAIL nozero_same got=%h exp=deadbeef", bus_b.rdata[63:32]);
    else pass_cnt++;
    bus_a.we0 = 1'b0;
    bus_b.we0 = 1'b0;
    tick();
    total_cnt++;
    if (bus_a.rdata[63:32] !== 32'h0)
      $display("FAIL zero_reg_later got=%h exp=0", bus_a.rdata[63:32]);
    else pass_cnt++;
    total_cnt++;
    if (bus_b.rdata[63:32] !== 32'hDEADBEEF)
      $display("FAIL nozero_later got=%h exp=deadbeef", bus_b.rdata[63:32]);
    else pass_cnt++;
  endtask

  task automatic test_bypass_all();
    bus_b.raddr = {5'd7, 5'd7, 5'd7, 5'd7};
    bus_b.we0 = 1'b1; bus_b.waddr0 = 5'd7; bus_b.wdata0 = 32'h0000_1234;
    tick();
    for (int p = 0; p < 4; p++) begin
      total_cnt++;
      if (bus_b.rdata[p*32 +: 32] !== 32'h0000_1234)
        $display("FAIL bypass_port%0d got=%h exp=00001234", p, bus_b.rdata[p*32 +: 32]);
      else pass_cnt++;
    end
    bus_b.we0 = 1'b0;
    tick();
    total_cnt++;
    if (bus_b.rdata[127:96] !== 32'h0000_1234)
      $display("FAIL bypass_persist got=%h exp=00001234", bus_b.rdata[127:96]);
    else pass_cnt++;
  endtask

  task automatic test_clear();
    logic exp_rdy;
    for (int r = 1; r < 32; r++) begin
      bus_a.we0 = 1'b1; bus_a.waddr0 = r[4:0]; bus_a.wdata0 = r;
      tick();
    end
    bus_a.we0 = 1'b0;
    bus_a.raddr = {5'd31, 5'd3};
    tick();
    total_cnt++;
    if (bus_a.rdata[31:0] !== 32'd3)
      $display("FAIL fill_reg3 got=%h exp=3", bus_a.rdata[31:0]);
    else pass_cnt++;
    total_cnt++;
    if (bus_a.rdata[63:32] !== 32'd31)
      $display("FAIL fill_reg31 got=%h exp=1f", bus_a.rdata[63:32]);
    else pass_cnt++;
    bus_a.clear = 1'b1;
    bus_a.we0 = 1'b1; bus_a.waddr0 = 5'd3; bus_a.wdata0 = 32'hFF;
    tick();
    total_cnt++;
    if (bus_a.ready !== 1'b0) $display("FAIL clear_ready_drop got=%b exp=0", bus_a.ready);
    else pass_cnt++;
    // Writes held during the sweep must be ignored.
    bus_a.clear = 1'b0;
    bus_a.waddr0 = 5'd4; bus_a.wdata0 = 32'h77;
    for (int i = 1; i <= 32; i++) begin
      tick();
      exp_rdy = (i == 32);
      total_cnt++;
      if (bus_a.ready !== exp_rdy)
        $display("FAIL clear_sweep_ready edge=%0d got=%b exp=%b", i, bus_a.ready, exp_rdy);
      else pass_cnt++;
      if (i == 5) begin
        total_cnt++;
        if (bus_a.rdata !== 64'h0) $display("FAIL clear_sweep_rdata got=%h exp=0", bus_a.rdata);
        else pass_cnt++;
      end
    end
    bus_a.we0 = 1'b0;
    for (int r = 0; r < 32; r++) begin
      bus_a.raddr[4:0] = r[4:0];
      tick();
      total_cnt++;
      if (bus_a.rdata[31:0] !== 32'h0)
        $display("FAIL clear_read reg=%0d got=%h exp=0", r, bus_a.rdata[31:0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_sweep();
    logic exp_rdy;
    bus_a.clear = 1'b1;
    tick();
    bus_a.clear = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    total_cnt++;
    if (bus_b.rdata[31:0] !== 32'h0000_1234)
      $display("FAIL pre_reset_b got=%h exp=00001234", bus_b.rdata[31:0]);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (bus_a.ready !== 1'b0) $display("FAIL midrst_ready_a got=%b exp=0", bus_a.ready);
    else pass_cnt++;
    total_cnt++;
    if (bus_b.ready !== 1'b0) $display("FAIL midrst_ready_b got=%b exp=0", bus_b.ready);
    else pass_cnt++;
    total_cnt++;
    if (bus_b.rdata !== 128'h0) $display("FAIL midrst_rdata_b got=%h exp=0", bus_b.rdata);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      tick();
      exp_rdy = (i == 32);
      total_cnt++;
      if (bus_a.ready !== exp_rdy)
        $display("FAIL midrst_sweep_ready edge=%0d got=%b exp=%b", i, bus_a.ready, exp_rdy);
      else pass_cnt++;
    end
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n = 1'b1;
    bus_a.clear = 1'b0; bus_a.raddr = '0;
    bus_a.we0 = 1'b0; bus_a.we1 = 1'b0;
    bus_a.waddr0 = '0; bus_a.waddr1 = '0; bus_a.wdata0 = '0; bus_a.wdata1 = '0;
    bus_b.clear = 1'b0; bus_b.raddr = '0;
    bus_b.we0 = 1'b0; bus_b.we1 = 1'b0;
    bus_b.waddr0 = '0; bus_b.waddr1 = '0; bus_b.wdata0 = '0; bus_b.wdata1 = '0;
    test_reset();
    test_collision();
    test_zero_reg();
    test_bypass_all();
    test_clear();
    test_reset_mid_sweep();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
